lfsr_seq_ctrl: RTL

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr64_step.sv | 15 +
 rtl/lfsr_seq_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 64-bit LFSR sequencer.
// Tap indices realise the polynomial x^64+x^63+x^61+x^60+1.
package lfsr_pkg;

  localparam int LFSR_W = 64;
  localparam int TAP_A  = 63;
  localparam int TAP_B  = 62;
  localparam int TAP_C  = 60;
  localparam int TAP_D  = 59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

endpackage

// File: rtl/lfsr64_step.sv
// One combinational step of the 64-bit Fibonacci LFSR.
// The feedback bit enters at the LSB while the register shifts left.
module lfsr64_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state
);

  logic feedback;

  assign feedback   = state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D];
  assign next_state = {state[LFSR_W-2:0], feedback};

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Seeded LFSR word generator with a run-length controlled output stream.
// All outputs decode directly from registers, so no input reaches an output combinationally.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [63:0]       seed,
  input  logic [LEN_W-1:0]  run_len,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              err_zero,
  output logic              period_hit,
  output logic [LEN_W-1:0]  step_count
);

  fsm_t              fsm_reg, fsm_next;
  logic [LFSR_W-1:0] state_reg, state_next;
  logic [LFSR_W-1:0] seed_reg, seed_next;
  logic [LFSR_W-1:0] stepped;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  step_count_reg, step_count_next;
  logic              err_zero_reg, err_zero_next;
  logic              period_hit_reg, period_hit_next;
  logic              seed_hs;

  lfsr64_step u_step (
    .state      (state_reg),
    .next_state (stepped)
  );

  assign seed_ready = (fsm_reg == ST_IDLE) || (fsm_reg == ST_ARMED);
  assign out_valid  = (fsm_reg == ST_RUN);
  assign busy       = (fsm_reg == ST_RUN);
  assign done       = (fsm_reg == ST_DONE);
  assign out_data   = state_reg;
  assign err_zero   = err_zero_reg;
  assign period_hit = period_hit_reg;
  assign step_count = step_count_reg;
  assign seed_hs    = seed_valid && seed_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg        <= ST_IDLE;
      state_reg      <= '0;
      seed_reg       <= '0;
      len_reg        <= '0;
      step_count_reg <= '0;
      err_zero_reg   <= 1'b0;
      period_hit_reg <= 1'b0;
    end else begin
      fsm_reg        <= fsm_next;
      state_reg      <= state_next;
      seed_reg       <= seed_next;
      len_reg        <= len_next;
      step_count_reg <= step_count_next;
      err_zero_reg   <= err_zero_next;
      period_hit_reg <= period_hit_next;
    end
  end

  always_comb begin
    fsm_next        = fsm_reg;
    state_next      = state_reg;
    seed_next       = seed_reg;
    len_next        = len_reg;
    step_count_next = step_count_reg;
    err_zero_next   = err_zero_reg;
    period_hit_next = period_hit_reg;

    case (fsm_reg)
      ST_IDLE, ST_ARMED: begin
        // Any seed handshake, even a rejected zero seed, takes precedence over start.
        if (seed_hs) begin
          if (seed != '0) begin
            state_next      = seed;
            seed_next       = seed;
            err_zero_next   = 1'b0;
            period_hit_next = 1'b0;
            fsm_next        = ST_ARMED;
          end else begin
            err_zero_next = 1'b1;
          end
        end else if ((fsm_reg == ST_ARMED) && start) begin
          len_next        = run_len;
          step_count_next = '0;
          fsm_next        = ST_RUN;
        end
      end

      ST_RUN: begin
        if (out_ready) begin
          state_next = stepped;
          if (!(&step_count_reg)) begin
            step_count_next = step_count_reg + LEN_W'(1);
          end
          if (stepped == seed_reg) begin
            period_hit_next = 1'b1;
          end
          if ((len_reg != '0) && ((step_count_reg + LEN_W'(1)) == len_reg)) begin
            fsm_next = ST_DONE;
          end
        end
        if (stop) begin
          fsm_next = ST_DONE;
        end
      end

      ST_DONE: begin
        fsm_next = ST_ARMED;
      end

      default: begin
        fsm_next = ST_IDLE;
      end
    endcase
  end

endmodule
